// File: rtl/fifo_drain_packer.sv
// Pops PACK_FACTOR entries from a fall-through fifo and presents them as one wide word.
// Word valid PACK_FACTOR-1 edges after first pop; holds word and stops popping until out_ready.
module fifo_drain_packer #(
  parameter int DATA_WIDTH  = 4,
  parameter int PACK_FACTOR = 3,
  parameter int CNT_WIDTH   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  input  logic                             fifo_empty_n,
  output logic                             fifo_deq,
  output logic [DATA_WIDTH*PACK_FACTOR-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CNT_WIDTH-1:0]             fill_cnt
);

  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(PACK_FACTOR - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                            state, state_nxt;
  logic [CNT_WIDTH-1:0]              cnt_nxt;
  logic [DATA_WIDTH*PACK_FACTOR-1:0] data_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= '0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= cnt_nxt;
      out_data <= data_nxt;
    end
  end

  // out_valid comes straight from the state flop, so it is glitch-free.
  assign out_valid = (state == HOLD);

  always_comb begin
    fifo_deq  = rst_n & ~clr & fifo_empty_n & ((state == FILL) | out_ready);
    state_nxt = state;
    cnt_nxt   = fill_cnt;
    data_nxt  = out_data;

    // fill_cnt is 0 in HOLD, so a pop on the release cycle lands in slot 0.
    if (fifo_deq) begin
      for (int i = 0; i < PACK_FACTOR; i++) begin
        if (fill_cnt == CNT_WIDTH'(i))
          data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
      end
    end

    if (clr) begin
      state_nxt = FILL;
      cnt_nxt   = '0;
      data_nxt  = '0;
    end else begin
      case (state)
        FILL: begin
          if (fifo_deq) begin
            if (fill_cnt == LAST_SLOT) begin
              state_nxt = HOLD;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = fill_cnt + CNT_WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nxt = FILL;
            cnt_nxt   = fifo_deq ? CNT_WIDTH'(1) : '0;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench: small fall-through fifo model feeding fifo_drain_packer (4-bit x 3).
module tb_fifo_drain_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [3:0]  fifo_dout;
  logic        fifo_empty_n;
  logic        fifo_deq;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  fill_cnt;

  int total = 0;
  int bad   = 0;

  logic [3:0] mem [0:31];
  logic [4:0] wr_ptr = '0;
  logic [4:0] rd_ptr = '0;

  always #5 clk = ~clk;

  assign fifo_empty_n = (wr_ptr != rd_ptr);
  assign fifo_dout    = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_deq) rd_ptr <= rd_ptr + 5'd1;
  end

  fifo_drain_packer #(.DATA_WIDTH(4), .PACK_FACTOR(3), .CNT_WIDTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .fifo_dout    (fifo_dout),
    .fifo_empty_n (fifo_empty_n),
    .fifo_deq     (fifo_deq),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fill_cnt     (fill_cnt)
  );

  task automatic push(input logic [3:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 5'd1;
  endtask

  // Next negedge plus settle time: away from the active edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [11:0] exp_w [0:2];

  initial begin
    exp_w[0] = 12'h321;
    exp_w[1] = 12'h654;
    exp_w[2] = 12'h987;
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_data", out_data, 12'h000);

    // Reset mid-fill: two entries captured, then reset.
    @(negedge clk); rst_n = 1'b1; push(4'hA); push(4'hB); #1;
    tick(); tick();
    chk("pre_rst_fill", fill_cnt, 2);
    @(negedge clk); rst_n = 1'b0; push(4'h1); push(4'h2); push(4'h3); #1;
    chk("deq_in_rst", fifo_deq, 0);
    tick();
    chk("midfill_rst_fill", fill_cnt, 0);
    chk("midfill_rst_valid", out_valid, 0);
    chk("midfill_rst_data", out_data, 12'h000);
    chk("deq_in_rst2", fifo_deq, 0);

    // Basic pack of 1,2,3.
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("basic_deq", fifo_deq, 1);
      chk("basic_fill", fill_cnt, i);
      chk("basic_nv", out_valid, 0);
      tick();
    end
    chk("basic_valid", out_valid, 1);
    chk("basic_data", out_data, 12'h321);
    chk("basic_deq_empty", fifo_deq, 0);
    tick();
    chk("basic_valid_1cyc", out_valid, 0);

    // Backpressure.
    @(negedge clk); out_ready = 1'b0;
    for (int v = 1; v <= 6; v++) push(4'(v));
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_deq_fill", fifo_deq, 1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_data_hold", out_data, 12'h321);
      chk("bp_deq_hold", fifo_deq, 0);
      tick();
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_release_deq", fifo_deq, 1);
    tick();
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_fill", fill_cnt, 1);
    chk("bp_after_deq", fifo_deq, 1);
    tick(); tick();
    chk("bp_word2_valid", out_valid, 1);
    chk("bp_word2_data", out_data, 12'h654);
    tick();
    chk("bp_word2_gone", out_valid, 0);
    chk("bp_word2_fill", fill_cnt, 0);

    // Empty stall.
    @(negedge clk); push(4'h1); push(4'h2); #1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_fill", fill_cnt, 2);
      chk("stall_valid", out_valid, 0);
      chk("stall_deq", fifo_deq, 0);
      tick();
    end
    @(negedge clk); push(4'h3); #1;
    chk("stall_resume_deq", fifo_deq, 1);
    tick();
    chk("stall_valid_word", out_valid, 1);
    chk("stall_data", out_data, 12'h321);
    tick();

    // clr mid-fill, then clr while a word is held.
    @(negedge clk); out_ready = 1'b0; push(4'h1); push(4'h2); #1;
    tick(); tick();
    chk("clr_pre_fill", fill_cnt, 2);
    @(negedge clk); clr = 1'b1; push(4'h7); push(4'h8); push(4'h9); #1;
    chk("clr_deq_block", fifo_deq, 0);
    tick();
    chk("clr_fill", fill_cnt, 0);
    chk("clr_data", out_data, 12'h000);
    @(negedge clk); clr = 1'b0; #1;
    tick(); tick(); tick();
    chk("clr_word_valid", out_valid, 1);
    chk("clr_word_data", out_data, 12'h987);
    @(negedge clk); clr = 1'b1; #1;
    tick();
    chk("clr_hold_valid", out_valid, 0);
    chk("clr_hold_data", out_data, 12'h000);
    chk("clr_hold_fill", fill_cnt, 0);
    @(negedge clk); clr = 1'b0; out_ready = 1'b1; #1;
    tick();
    chk("clr_dropped", out_valid, 0);

    // Streaming 9 entries.
    @(negedge clk);
    for (int v = 1; v <= 9; v++) push(4'(v));
    #1;
    for (int i = 0; i < 9; i++) begin
      chk("stream_deq", fifo_deq, 1);
      tick();
      chk("stream_valid", out_valid, ((i % 3) == 2) ? 1 : 0);
      chk("stream_fill", fill_cnt, (i + 1) % 3);
      if ((i % 3) == 2) chk("stream_data", out_data, exp_w[i/3]);
    end
    chk("stream_end_deq", fifo_deq, 0);
    tick();
    chk("stream_end_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
